mem_port_arbiter: RTL

- Shares one single-ported memory between the CPU instruction-fetch port and its data-load/store port.
- Arbitrates between the two, sequences each access through issue, wait and response, and enforces a bounded wait for read data.
- Sits between the multicycle rv32i core and a unified instruction/data RAM.
- Lets a single memory replace separate instruction and data memories.

---
 rtl/mem_port_arbiter.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//
// Shares one single-ported unified RAM between the instruction-fetch port and
// the data load/store port of a multicycle rv32i core. Each access goes
// IDLE -> ISSUE -> (WAIT) -> RESP -> IDLE. Stores skip WAIT because the memory
// commits on the ISSUE edge. Reads wait for mem_rvalid for at most MAX_WAIT
// cycles. A timed-out read returns zero and pulses timeout_err.
//
// Optional feature, selected by the macro ARB_ROUND_ROBIN_EN:
//   defined   - contended grants alternate between the two ports.
//   undefined - the data port always wins contention.
//
// Parameters:
//   ADDR_WIDTH  width of every address bus
//   MAX_WAIT    WAIT cycles allowed before a read times out (1..15)
//
// Ports:
//   clk, reset                 rising-edge clock, asynchronous active-low reset
//   if_req, if_addr            fetch request, held until if_valid
//   if_valid, if_rdata         fetch response pulse and held fetch word
//   d_req, d_addr, d_wmask,
//   d_wdata                    data request (wmask 0 = load), held until d_valid
//   d_valid, d_rdata           data response pulse and held load word
//   mem_req                    one-cycle memory strobe
//   mem_addr, mem_wmask,
//   mem_wdata                  latched access presented to the RAM
//   mem_rdata, mem_rvalid      RAM read return
//   busy                       high whenever an access is in flight
//   timeout_err                one-cycle pulse on a read timeout
module mem_port_arbiter #(
    parameter int ADDR_WIDTH = 16,
    parameter int MAX_WAIT   = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_valid,
    output logic [31:0]           if_rdata,
    input  logic                  d_req,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [3:0]            d_wmask,
    input  logic [31:0]           d_wdata,
    output logic                  d_valid,
    output logic [31:0]           d_rdata,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [3:0]            mem_wmask,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata,
    input  logic                  mem_rvalid,
    output logic                  busy,
    output logic                  timeout_err
);

    localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_next_state;

    logic [3:0]            r_wait_cnt;
    logic                  r_owner;        // 0 = fetch, 1 = data
    logic                  r_if_valid;
    logic                  r_d_valid;
    logic                  r_mem_req;
    logic                  r_busy;
    logic                  r_timeout_err;
    logic [31:0]           r_if_rdata;
    logic [31:0]           r_d_rdata;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [3:0]            r_mem_wmask;
    logic [31:0]           r_mem_wdata;

    logic                  w_any_req;
    logic                  w_grant_data;
    logic                  w_is_store;
    logic                  w_timeout;
    logic [3:0]            w_wait_inc;

    assign w_any_req  = if_req | d_req;
    assign w_is_store = (r_mem_wmask != 4'd0);
    assign w_wait_inc = r_wait_cnt + 4'd1;
    // A late mem_rvalid on the final allowed cycle still wins over the timeout.
    assign w_timeout  = (r_state == S_WAIT) && !mem_rvalid && (w_wait_inc == MAX_WAIT_C);

`ifdef ARB_ROUND_ROBIN_EN
    // Remembers which port won the last contended arbitration (1 = data).
    // Starts as "fetch won" so the first contention goes to data.
    logic r_last_data;

    assign w_grant_data = d_req & (~if_req | ~r_last_data);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_last_data <= 1'b0;
        end else if ((r_state == S_IDLE) && if_req && d_req) begin
            r_last_data <= w_grant_data;
        end
    end
`else
    assign w_grant_data = d_req;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_any_req) w_next_state = S_ISSUE;
            S_ISSUE: w_next_state = w_is_store ? S_RESP : S_WAIT;
            S_WAIT:  if (mem_rvalid || w_timeout) w_next_state = S_RESP;
            S_RESP:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Every output is registered from the next state so that pulses line up
    // with the state they belong to (mem_req in ISSUE, valids in RESP).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wait_cnt    <= 4'd0;
            r_owner       <= 1'b0;
            r_if_valid    <= 1'b0;
            r_d_valid     <= 1'b0;
            r_mem_req     <= 1'b0;
            r_busy        <= 1'b0;
            r_timeout_err <= 1'b0;
            r_if_rdata    <= 32'd0;
            r_d_rdata     <= 32'd0;
            r_mem_addr    <= '0;
            r_mem_wmask   <= 4'd0;
            r_mem_wdata   <= 32'd0;
        end else begin
            r_mem_req     <= (w_next_state == S_ISSUE);
            r_busy        <= (w_next_state != S_IDLE);
            r_if_valid    <= (w_next_state == S_RESP) && !r_owner;
            r_d_valid     <= (w_next_state == S_RESP) && r_owner;
            r_timeout_err <= w_timeout;

            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_owner <= w_grant_data;
                        if (w_grant_data) begin
                            r_mem_addr  <= d_addr;
                            r_mem_wmask <= d_wmask;
                            r_mem_wdata <= d_wdata;
                        end else begin
                            r_mem_addr  <= if_addr;
                            r_mem_wmask <= 4'd0;
                            r_mem_wdata <= 32'd0;
                        end
                    end
                end
                S_ISSUE: begin
                    r_wait_cnt <= 4'd0;
                end
                S_WAIT: begin
                    if (mem_rvalid) begin
                        if (r_owner) r_d_rdata  <= mem_rdata;
                        else         r_if_rdata <= mem_rdata;
                    end else if (w_timeout) begin
                        if (r_owner) r_d_rdata  <= 32'd0;
                        else         r_if_rdata <= 32'd0;
                    end else begin
                        r_wait_cnt <= w_wait_inc;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign if_valid    = r_if_valid;
    assign if_rdata    = r_if_rdata;
    assign d_valid     = r_d_valid;
    assign d_rdata     = r_d_rdata;
    assign mem_req     = r_mem_req;
    assign mem_addr    = r_mem_addr;
    assign mem_wmask   = r_mem_wmask;
    assign mem_wdata   = r_mem_wdata;
    assign busy        = r_busy;
    assign timeout_err = r_timeout_err;

endmodule
